// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART word scheduler.
// Optional build macro: UART_SCHED_HEADER_EN adds the SYNC_HDR byte ahead of every word.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned TIMER_W        = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [BYTE_W-1:0] SYNC_HDR = 8'hA5;

`ifdef UART_SCHED_HEADER_EN
    localparam int unsigned HDR_BYTES = 1;
`else
    localparam int unsigned HDR_BYTES = 0;
`endif

    // Bytes on the line per word, and the width of the byte counter that walks them
    localparam int unsigned FRAME_BYTES = BYTES_PER_WORD + HDR_BYTES;
    localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);

    // A requester word viewed as its four byte lanes (b0 = bits [7:0])
    typedef struct packed {
        logic [BYTE_W-1:0] b3;
        logic [BYTE_W-1:0] b2;
        logic [BYTE_W-1:0] b1;
        logic [BYTE_W-1:0] b0;
    } word_bytes_t;

    // Pick the idx-th payload byte in transmit order
    function automatic logic [BYTE_W-1:0] byte_sel(
        input word_bytes_t word,
        input logic [1:0]  idx,
        input logic        msb_first
    );
        logic [1:0] lane;
        lane = msb_first ? 2'(2'd3 - idx) : idx;
        case (lane)
            2'd0:    byte_sel = word.b0;
            2'd1:    byte_sel = word.b1;
            2'd2:    byte_sel = word.b2;
            default: byte_sel = word.b3;
        endcase
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or after ptr wins (combinational).
module uart_rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant_c,
    output logic [$clog2(N_REQ)-1:0] grant_idx_c,
    output logic                     any_c
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    // Scan requesters starting at ptr, wrapping modulo N_REQ; first hit wins
    always_comb begin
        int unsigned idx;
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        idx         = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = (32'(ptr) + off) % N_REQ;
            if (!any_c && req[ID_W'(idx)]) begin
                any_c                 = 1'b1;
                grant_c[ID_W'(idx)]   = 1'b1;
                grant_idx_c           = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_word_scheduler.sv
// Shares one byte-wide UART transmitter between N_REQ word sources: round-robin
// arbitration, word capture, and byte sequencing over the tx_en/tx_busy handshake.
// Optional build macro: UART_SCHED_HEADER_EN sends SYNC_HDR before each word (5 bytes).
module uart_tx_word_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned        N_REQ         = 2,
    parameter bit                 MSB_FIRST     = 1'b0,
    parameter logic [TIMER_W-1:0] START_TIMEOUT = 16'd40000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [WORD_W*N_REQ-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [BYTE_W-1:0]          tx_data,
    output logic                       tx_en,
    input  logic                       tx_busy,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       word_done,
    output logic                       err_timeout
);

    localparam int unsigned       ID_W     = $clog2(N_REQ);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    state_t               state_q, state_d;
    word_bytes_t          word_q, word_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0]     req_ready_d;
    logic [BYTE_W-1:0]    tx_data_d;
    logic                 tx_en_d;
    logic                 busy_d;
    logic [ID_W-1:0]      grant_id_d;
    logic                 word_done_d;
    logic                 err_timeout_d;

    logic [N_REQ-1:0]     arb_grant_c;
    logic [ID_W-1:0]      arb_idx_c;
    logic                 arb_any_c;
    word_bytes_t          sel_word_c;
    logic [BYTE_W-1:0]    cur_byte_c;
    logic [ID_W-1:0]      next_ptr_c;

    word_bytes_t          req_words [N_REQ];

    uart_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant_c     (arb_grant_c),
        .grant_idx_c (arb_idx_c),
        .any_c       (arb_any_c)
    );

    // Unpack the flat request bus into one word per requester
    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign req_words[g] = req_data[WORD_W*g +: WORD_W];
    end

    // Word offered by the arbitration winner
    always_comb begin
        sel_word_c = req_words[arb_idx_c];
    end

    // Byte for the current position in the frame
    always_comb begin
`ifdef UART_SCHED_HEADER_EN
        if (byte_idx_q == '0) begin
            cur_byte_c = SYNC_HDR;
        end else begin
            cur_byte_c = byte_sel(word_q, 2'(byte_idx_q - IDX_W'(1)), MSB_FIRST);
        end
`else
        cur_byte_c = byte_sel(word_q, byte_idx_q, MSB_FIRST);
`endif
    end

    // Round-robin pointer moves to the requester after the one just served
    always_comb begin
        if (grant_id == ID_W'(N_REQ - 1)) begin
            next_ptr_c = '0;
        end else begin
            next_ptr_c = grant_id + ID_W'(1);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        byte_idx_d    = byte_idx_q;
        timer_d       = timer_q;
        rr_ptr_d      = rr_ptr_q;
        req_ready_d   = '0;
        tx_data_d     = tx_data;
        tx_en_d       = 1'b0;
        busy_d        = busy;
        grant_id_d    = grant_id;
        word_done_d   = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Arbitrate only while the transmitter is free
                if (!tx_busy && arb_any_c) begin
                    req_ready_d = arb_grant_c;
                    word_d      = sel_word_c;
                    grant_id_d  = arb_idx_c;
                    busy_d      = 1'b1;
                    byte_idx_d  = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_d = cur_byte_c;
                tx_en_d   = 1'b1;
                timer_d   = '0;
                state_d   = S_WAIT_START;
            end
            S_WAIT_START: begin
                // tx_data stays put: the transmitter keeps sampling it until busy rises
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q >= START_TIMEOUT) begin
                    err_timeout_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (byte_idx_q == LAST_IDX) begin
                        word_done_d = 1'b1;
                        busy_d      = 1'b0;
                        rr_ptr_d    = next_ptr_c;
                        state_d     = S_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        state_d    = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            byte_idx_q  <= '0;
            timer_q     <= '0;
            rr_ptr_q    <= '0;
            req_ready   <= '0;
            tx_data     <= '0;
            tx_en       <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            word_done   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            timer_q     <= timer_d;
            rr_ptr_q    <= rr_ptr_d;
            req_ready   <= req_ready_d;
            tx_data     <= tx_data_d;
            tx_en       <= tx_en_d;
            busy        <= busy_d;
            grant_id    <= grant_id_d;
            word_done   <= word_done_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_word_scheduler.sv
// Bench for uart_tx_word_scheduler: a serial transmitter model (BAUD_DIVISOR=4) with an
// RX decoder on DUT0 (MSB_FIRST=0, START_TIMEOUT=50), and a byte-capture responder on
// DUT1 (MSB_FIRST=1). Honours UART_SCHED_HEADER_EN for the expected byte streams.
module tb_uart_tx_word_scheduler;

`ifdef UART_SCHED_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int NB = HDR ? 5 : 4;

    logic        clk;
    logic        reset_n;

    logic [1:0]  req_valid0, req_ready0, req_valid1, req_ready1;
    logic [63:0] req_data0, req_data1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_en0, tx_en1, busy0, busy1;
    logic [0:0]  grant0, grant1;
    logic        word_done0, word_done1, err0, err1;
    logic        tx_busy_m, tx_busy_dut0, tie_low, busy_r1;

    int errors = 0;
    int checks = 0;

    uart_tx_word_scheduler #(.N_REQ(2), .MSB_FIRST(1'b0), .START_TIMEOUT(16'd50)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .tx_data(tx_data0), .tx_en(tx_en0), .tx_busy(tx_busy_dut0),
        .busy(busy0), .grant_id(grant0), .word_done(word_done0), .err_timeout(err0));

    uart_tx_word_scheduler #(.N_REQ(2), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid1), .req_data(req_data1),
        .req_ready(req_ready1), .tx_data(tx_data1), .tx_en(tx_en1), .tx_busy(busy_r1),
        .busy(busy1), .grant_id(grant1), .word_done(word_done1), .err_timeout(err1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: 8N1, 5 clocks per bit
    logic [9:0] frame;
    logic [3:0] bitcnt;
    logic [2:0] divcnt;
    logic       line;
    assign line         = tx_busy_m ? frame[0] : 1'b1;
    assign tx_busy_dut0 = tx_busy_m & ~tie_low;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_busy_m <= 1'b0; frame <= '1; bitcnt <= '0; divcnt <= '0;
        end else if (!tx_busy_m) begin
            if (tx_en0) begin
                tx_busy_m <= 1'b1; frame <= {1'b1, tx_data0, 1'b0};
                bitcnt <= '0; divcnt <= '0;
            end
        end else if (divcnt == 3'd4) begin
            divcnt <= '0;
            frame  <= {1'b1, frame[9:1]};
            if (bitcnt == 4'd9) tx_busy_m <= 1'b0;
            else bitcnt <= bitcnt + 4'd1;
        end else begin
            divcnt <= divcnt + 3'd1;
        end
    end

    // RX decoder on the serial line
    logic [7:0] rx_q[$];
    logic [7:0] rx_b;
    always begin
        @(negedge clk);
        if (reset_n && line == 1'b0) begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (5) @(negedge clk);
                rx_b[i] = line;
            end
            repeat (5) @(negedge clk);
            rx_q.push_back(rx_b);
        end
    end

    // DUT1 responder: samples tx_data one cycle after tx_en, then busy for a few cycles
    logic [7:0] cap_q[$];
    logic       pend1;
    logic [2:0] cnt1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r1 <= 1'b0; pend1 <= 1'b0; cnt1 <= '0;
        end else begin
            if (!busy_r1 && tx_en1) pend1 <= 1'b1;
            if (pend1) begin
                cap_q.push_back(tx_data1);
                busy_r1 <= 1'b1; cnt1 <= 3'd6; pend1 <= 1'b0;
            end else if (busy_r1) begin
                if (cnt1 == 3'd0) busy_r1 <= 1'b0;
                else cnt1 <= cnt1 - 3'd1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [39:0] exp_frame(input logic [31:0] w, input bit msb);
        logic [39:0] f;
        int j;
        f = '0;
        for (int k = 0; k < NB; k++) begin
            if (HDR && k == 0) begin
                f[8*k +: 8] = 8'hA5;
            end else begin
                j = HDR ? k - 1 : k;
                f[8*k +: 8] = msb ? w[8*(3-j) +: 8] : w[8*j +: 8];
            end
        end
        return f;
    endfunction

    function automatic logic [39:0] pop_rx();
        logic [39:0] f;
        f = '0;
        for (int k = 0; k < NB; k++) if (rx_q.size() > 0) f[8*k +: 8] = rx_q.pop_front();
        return f;
    endfunction

    task automatic wait_ready0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready0 != 2'b00) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_done0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (word_done0) begin ok = 1'b1; return; end
        end
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [0:0]  exp_grant;
        logic [31:0] exp_word;
    } vec_t;
    vec_t vecs[10];

    initial begin
        bit          ok;
        int          n, wd, rp, cnt;
        logic [39:0] got;
        logic [1:0]  oh;

        vecs[0] = '{2'b01, 32'h11223344, 32'h00000000, 1'b0, 32'h11223344};
        vecs[1] = '{2'b10, 32'h00000000, 32'h55667788, 1'b1, 32'h55667788};
        vecs[2] = '{2'b11, 32'hAAAA0001, 32'hBBBB0002, 1'b0, 32'hAAAA0001};
        vecs[3] = '{2'b11, 32'hAAAA0001, 32'hBBBB0002, 1'b1, 32'hBBBB0002};
        vecs[4] = '{2'b11, 32'hAAAA0001, 32'hBBBB0002, 1'b0, 32'hAAAA0001};
        vecs[5] = '{2'b11, 32'hAAAA0001, 32'hBBBB0002, 1'b1, 32'hBBBB0002};
        vecs[6] = '{2'b11, 32'hAAAA0001, 32'hBBBB0002, 1'b0, 32'hAAAA0001};
        vecs[7] = '{2'b11, 32'hAAAA0001, 32'hBBBB0002, 1'b1, 32'hBBBB0002};
        vecs[8] = '{2'b01, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'hCAFEF00D};
        vecs[9] = '{2'b01, 32'h000000FF, 32'h00000000, 1'b0, 32'h000000FF};

        reset_n = 1'b0; tie_low = 1'b0;
        req_valid0 = '0; req_data0 = '0; req_valid1 = '0; req_data1 = '0;
        #12;
        check("reset_outputs_dut0", {req_ready0, tx_data0, tx_en0, busy0, grant0, word_done0, err0}, 0);
        check("reset_outputs_dut1", {req_ready1, tx_data1, tx_en1, busy1, grant1, word_done1, err1}, 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // MSB-first word on DUT1
        req_data1 = {32'h0, 32'hDEADBEEF}; req_valid1 = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready1 != 2'b00) ok = 1'b1;
        end
        check("msb_ready_seen", ok, 1);
        req_valid1 = '0;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (word_done1) ok = 1'b1;
        end
        check("msb_done_seen", ok, 1);
        check("msb_byte_count", cap_q.size(), NB);
        got = '0;
        for (int k = 0; k < NB; k++) if (cap_q.size() > 0) got[8*k +: 8] = cap_q.pop_front();
        check("msb_frame", got, exp_frame(32'hDEADBEEF, 1'b1));

        // Table of single-word transactions on DUT0
        for (int v = 0; v < 10; v++) begin
            req_data0  = {vecs[v].d1, vecs[v].d0};
            req_valid0 = vecs[v].mask;
            wait_ready0(ok);
            check($sformatf("vec%0d_ready_seen", v), ok, 1);
            oh = 2'b01 << vecs[v].exp_grant;
            check($sformatf("vec%0d_ready_onehot", v), req_ready0, oh);
            check($sformatf("vec%0d_grant", v), grant0, vecs[v].exp_grant);
            req_valid0 = '0;
            @(negedge clk);
            check($sformatf("vec%0d_tx_en_latency", v), tx_en0, 1);
            wait_done0(ok);
            check($sformatf("vec%0d_done_seen", v), ok, 1);
            check($sformatf("vec%0d_busy_low", v), busy0, 0);
            check($sformatf("vec%0d_byte_count", v), rx_q.size(), NB);
            got = pop_rx();
            check($sformatf("vec%0d_frame", v), got, exp_frame(vecs[v].exp_word, 1'b0));
        end

        // req_valid held high: one ready pulse per finished word
        req_data0 = {32'h0, 32'h01020304}; req_valid0 = 2'b01;
        rp = 0; wd = 0;
        for (int i = 0; i < 3000 && wd < 3; i++) begin
            @(negedge clk);
            if (req_ready0 != 2'b00) rp++;
            if (word_done0) wd++;
        end
        req_valid0 = '0;
        check("held_word_done_count", wd, 3);
        check("held_ready_count", rp, 3);
        check("held_byte_count", rx_q.size(), 3 * NB);
        rx_q.delete();

        // Start timeout: transmitter busy never seen
        tie_low = 1'b1;
        req_data0 = {32'h0, 32'h00000077}; req_valid0 = 2'b01;
        wait_ready0(ok);
        check("to_ready_seen", ok, 1);
        req_valid0 = '0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (tx_en0) ok = 1'b1;
        end
        check("to_tx_en_seen", ok, 1);
        n = 0; wd = 0; ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (word_done0) wd++;
            if (err0) ok = 1'b1;
        end
        check("to_err_seen", ok, 1);
        check("to_err_delay", n, 51);
        check("to_busy_low", busy0, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (word_done0) wd++;
        end
        check("to_no_word_done", wd, 0);
        tie_low = 1'b0;
        rx_q.delete();

        // Reset while byte 2 is on the line
        req_data0 = {32'h0, 32'h01020304}; req_valid0 = 2'b01;
        wait_ready0(ok);
        check("rst_ready_seen", ok, 1);
        req_valid0 = '0;
        cnt = 0;
        for (int i = 0; i < 1000 && cnt < 3; i++) begin
            @(negedge clk);
            if (tx_en0) cnt++;
        end
        check("rst_third_tx_en", cnt, 3);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_outputs_midword", {req_ready0, tx_data0, tx_en0, busy0, grant0, word_done0, err0}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (120) @(negedge clk);
        rx_q.delete();
        req_data0 = {32'hBBBB0002, 32'h0A0B0C0D}; req_valid0 = 2'b11;
        wait_ready0(ok);
        check("post_rst_ready_seen", ok, 1);
        check("post_rst_grant", grant0, 0);
        req_valid0 = '0;
        wait_done0(ok);
        check("post_rst_done_seen", ok, 1);
        check("post_rst_byte_count", rx_q.size(), NB);
        got = pop_rx();
        check("post_rst_frame", got, exp_frame(32'h0A0B0C0D, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
